// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and bit-counter width.
package subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Wide enough to count WIDTH-1 for the largest legal WIDTH of 16.
    localparam int CNT_W = 4;

endpackage

// File: rtl/subtractor_full.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module subtractor_full (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor: accepts num1/num2/inborrow on a valid/ready handshake,
// computes num1 - num2 - inborrow one bit per clock, LSB first.
module subtractor_serial
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             inborrow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             outborrow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               borrow_q,    borrow_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               outborrow_q, outborrow_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               bit_d_s;
    logic               bit_bout_s;

    subtractor_full u_full (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (bit_d_s),
        .bout (bit_bout_s)
    );

    // Next-state, datapath and handshake-output computation.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        outborrow_d = outborrow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = num1;
                    b_d      = num2;
                    borrow_d = inborrow;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                // The minuend register doubles as the result accumulator: each
                // result bit enters at the MSB as the consumed LSB leaves.
                a_d      = {bit_d_s, a_q[WIDTH-1:1]};
                b_d      = {1'b0, b_q[WIDTH-1:1]};
                borrow_d = bit_bout_s;
                if (cnt_q == CNT_LAST) begin
                    diff_d      = {bit_d_s, a_q[WIDTH-1:1]};
                    outborrow_d = bit_bout_s;
                    state_d     = DONE;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            borrow_q    <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            diff_q      <= {WIDTH{1'b0}};
            outborrow_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            outborrow_q <= outborrow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign outborrow = outborrow_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial at WIDTH=4 and WIDTH=8, compared
// every cycle against an arithmetic transaction model.
module tb_subtractor_serial;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;
    bit   done_w [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int w, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s (WIDTH=%0d): got %0d, expected %0d", nm, w, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_w
        localparam int W = (g == 0) ? 4 : 8;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] num1;
        logic [W-1:0] num2;
        logic         inborrow;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] diff;
        logic         outborrow;
        bit           chk_en = 1'b0;

        subtractor_serial #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .num1      (num1),
            .num2      (num2),
            .inborrow  (inborrow),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .diff      (diff),
            .outborrow (outborrow)
        );

        // Transaction model: one operation in flight, result shown W+1 edges
        // after acceptance (acceptance edge counted), held until consumed.
        int           m_r;
        bit           m_busy = 1'b0;
        int           m_age = 0;
        int           m_acc = 0;
        logic [W-1:0] m_pend_diff = '0;
        logic         m_pend_b = 1'b0;
        logic [W-1:0] m_show_diff = '0;
        logic         m_show_b = 1'b0;

        assign m_r = int'(num1) - int'(num2) - int'(inborrow);

        always @(posedge clk) begin
            if (!rst_n) begin
                m_busy      <= 1'b0;
                m_age       <= 0;
                m_show_diff <= '0;
                m_show_b    <= 1'b0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy      <= 1'b1;
                    m_age       <= 1;
                    m_pend_diff <= W'(m_r);
                    m_pend_b    <= (m_r < 0);
                    m_acc       <= m_acc + 1;
                end
            end else if (m_age < W + 1) begin
                m_age <= m_age + 1;
                if (m_age == W) begin
                    m_show_diff <= m_pend_diff;
                    m_show_b    <= m_pend_b;
                end
            end else if (out_ready) begin
                m_busy <= 1'b0;
            end
        end

        // Per-cycle comparison of every DUT output against the model.
        initial begin
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    n_vec++;
                    if (in_ready !== !m_busy || out_valid !== (m_busy && m_age == W + 1) ||
                        diff !== m_show_diff || outborrow !== m_show_b) begin
                        n_err++;
                        $display("FAIL cycle_check (WIDTH=%0d) t=%0t: got rdy=%b vld=%b diff=%h bo=%b, expected rdy=%b vld=%b diff=%h bo=%b",
                                 W, $time, in_ready, out_valid, diff, outborrow,
                                 !m_busy, (m_busy && m_age == W + 1), m_show_diff, m_show_b);
                    end
                end
            end
        end

        task automatic run_op(input logic [15:0] n1, input logic [15:0] n2, input logic bin,
                              input int hold, input logic [15:0] exp_d, input logic exp_b,
                              input string nm);
            int t;
            int lat;
            @(negedge clk);
            num1      = W'(n1);
            num2      = W'(n2);
            inborrow  = bin;
            in_valid  = 1'b1;
            out_ready = 1'b0;
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            num1     = W'($urandom);
            num2     = W'($urandom);
            inborrow = 1'($urandom);
            lat = 1;
            while (!out_valid && lat < 3 * W) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk({nm, "_latency"}, W, lat, W + 1);
            chk({nm, "_diff"}, W, int'(diff), int'(exp_d[W-1:0]));
            chk({nm, "_borrow"}, W, int'(outborrow), int'(exp_b));
            repeat (hold) @(negedge clk);
            chk({nm, "_held_diff"}, W, int'(diff), int'(exp_d[W-1:0]));
            chk({nm, "_held_valid"}, W, int'(out_valid), 1);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({nm, "_back_to_idle"}, W, int'(in_ready), 1);
        endtask

        initial begin
            int start;
            int c;
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            num1      = '0;
            num2      = '0;
            inborrow  = 1'b0;
            repeat (2) @(negedge clk);
            rst_n  = 1'b1;
            chk_en = 1'b1;
            chk("reset_diff", W, int'(diff), 0);
            chk("reset_in_ready", W, int'(in_ready), 1);
            chk("reset_out_valid", W, int'(out_valid), 0);

            run_op(16'hD, 16'hF, 1'b0, 0, (W == 4) ? 16'h0E : 16'hFE, 1'b1, "d1101_1111");
            run_op(16'h8, 16'h5, 1'b1, 0, 16'h02, 1'b0, "d1000_0101");
            run_op(16'h0, 16'h0, 1'b1, 6, (W == 4) ? 16'h0F : 16'hFF, 1'b1, "d0000_0000_hold");

            // Reset on the second SHIFT cycle, with in_valid asserted at the reset edge.
            @(negedge clk);
            num1     = W'(4'hD);
            num2     = W'(4'h6);
            inborrow = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            rst_n    = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            rst_n    = 1'b1;
            in_valid = 1'b0;
            chk("midreset_diff", W, int'(diff), 0);
            chk("midreset_in_ready", W, int'(in_ready), 1);
            repeat (W + 3) begin
                @(negedge clk);
                chk("midreset_no_valid", W, int'(out_valid), 0);
            end
            run_op(16'h7, 16'h3, 1'b0, 0, 16'h04, 1'b0, "d0111_0011");

            // Random traffic with backpressure and in_valid toggling while busy.
            start = m_acc;
            c = 0;
            while (m_acc < start + 1000 && c < 40000) begin
                @(negedge clk);
                in_valid  = ($urandom_range(3) != 0);
                num1      = W'($urandom);
                num2      = W'($urandom);
                inborrow  = 1'($urandom);
                out_ready = 1'($urandom);
                c++;
            end
            chk("random_ops_completed", W, (m_acc >= start + 1000) ? 1 : 0, 1);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (W + 4) @(negedge clk);
            done_w[g] = 1'b1;
        end
    end

    initial begin
        int c;
        c = 0;
        while (!(done_w[0] && done_w[1]) && c < 90000) begin
            @(posedge clk);
            c++;
        end
        if (!(done_w[0] && done_w[1])) begin
            n_err++;
            $display("FAIL global_timeout: got done=%b%b, expected 11", done_w[1], done_w[0]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
